// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: drains a sample FIFO into an AXI4-Stream master framed as PKT_LEN-beat packets.
// Latency: rd_en to TVALID is 2 cycles; 1 beat/cycle sustained while TREADY is held high.
// Backpressure: 2-entry output buffer; reads stop when buffered + in-flight words would exceed it.
// Optional packet statistics counter: define FIFO_AXIS_DRAIN_STATS_EN.
module fifo_axis_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_LEN - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    issue_cnt_q, issue_cnt_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic [1:0]              occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   buf0_dat_q, buf0_dat_d;
    logic [DATA_WIDTH-1:0]   buf1_dat_q, buf1_dat_d;
    logic                    buf0_last_q, buf0_last_d;
    logic                    buf1_last_q, buf1_last_d;

    logic                    read_allowed;
    logic                    pop;
    logic                    issue_last;
    logic [1:0]              occ_after_pop;

    // ---------------- state machine ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!enable) state_d = (issue_cnt_q == '0) ? S_IDLE : S_FINISH;
            end
            S_FINISH: begin
                if (enable)                  state_d = S_RUN;
                else if (issue_cnt_q == '0)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A packet boundary with enable low never opens a new packet, keeping packets atomic.
    always_comb begin
        read_allowed = 1'b0;
        case (state_q)
            S_RUN:    read_allowed = enable || (issue_cnt_q != '0);
            S_FINISH: read_allowed = (issue_cnt_q != '0);
            default:  read_allowed = 1'b0;
        endcase
    end

    // ---------------- read issue ----------------
    assign M_AXIS_TVALID = (occ_q != 2'd0);
    assign M_AXIS_TDATA  = buf0_dat_q;
    assign M_AXIS_TLAST  = buf0_last_q && M_AXIS_TVALID;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign issue_last    = (issue_cnt_q == LAST_IDX);

    // Counting this cycle's pop lets a read overlap the drain for full throughput.
    assign rd_en = read_allowed && !fifo_empty &&
                   ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

    always_comb begin
        issue_cnt_d     = issue_cnt_q;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && issue_last;
        if (rd_en) begin
            issue_cnt_d = issue_last ? '0 : issue_cnt_q + 1'b1;
        end
    end

    // ---------------- output buffer ----------------
    always_comb begin
        buf0_dat_d  = buf0_dat_q;
        buf0_last_d = buf0_last_q;
        buf1_dat_d  = buf1_dat_q;
        buf1_last_d = buf1_last_q;
        occ_d       = occ_after_pop + {1'b0, inflight_q};
        if (pop) begin
            buf0_dat_d  = buf1_dat_q;
            buf0_last_d = buf1_last_q;
        end
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                buf0_dat_d  = data_out;
                buf0_last_d = inflight_last_q;
            end else begin
                buf1_dat_d  = data_out;
                buf1_last_d = inflight_last_q;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            buf0_dat_q      <= '0;
            buf0_last_q     <= 1'b0;
            buf1_dat_q      <= '0;
            buf1_last_q     <= 1'b0;
        end else begin
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            buf0_dat_q      <= buf0_dat_d;
            buf0_last_q     <= buf0_last_d;
            buf1_dat_q      <= buf1_dat_d;
            buf1_last_q     <= buf1_last_d;
        end
    end

    assign busy = (state_q != S_IDLE) || (occ_q != 2'd0) || inflight_q;

    // ---------------- packet statistics ----------------
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pop && M_AXIS_TLAST) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Bench for fifo_axis_drain: FIFO source and stream sink modelled with queues; every
// handshake is scored against source order and a beat-index-derived TLAST.
module tb_fifo_axis_drain;
    localparam int DW = 32;
    localparam int PL = 8;
    localparam int CW = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          enable;
    logic          fifo_empty;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;
    logic          busy;
    logic [CW-1:0] pkt_count;

    fifo_axis_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .fifo_empty(fifo_empty),
        .rd_en(rd_en), .data_out(data_out), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST(M_AXIS_TLAST), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 ACLK = ~ACLK;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] fifo_q[$];   // words still held by the source FIFO
    logic [DW-1:0] exp_q[$];    // words read out but not yet seen on the stream
    int            beat, pkts, n_fired, cyc, base;
    int            first_rd, first_v, first_hs, last_hs;
    bit            hold_empty;
    logic [DW-1:0] next_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [CW-1:0] exp_pkts();
`ifdef FIFO_AXIS_DRAIN_STATS_EN
        return CW'(pkts);
`else
        return '0;
`endif
    endfunction

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
    endtask

    // One clock cycle: sample just before the edge, then update the FIFO model after it.
    task automatic tick();
        logic          fire, stall, p_last;
        logic [DW-1:0] p_dat, w;
        fifo_empty = (fifo_q.size() == 0) || hold_empty;
        #1;
        fire = rd_en;
        if (fire && first_rd < 0) first_rd = cyc;
        if (M_AXIS_TVALID && first_v < 0) first_v = cyc;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            chk("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("tdata", M_AXIS_TDATA, w);
                chk("tlast", M_AXIS_TLAST, (beat % PL) == PL - 1);
            end
            if ((beat % PL) == PL - 1) pkts++;
            beat++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        stall  = M_AXIS_TVALID && !M_AXIS_TREADY;
        p_dat  = M_AXIS_TDATA;
        p_last = M_AXIS_TLAST;
        @(posedge ACLK);
        #1;
        cyc++;
        if (fire) begin
            n_fired++;
            chk("read_nonempty", fifo_q.size() > 0, 1'b1);
            if (fifo_q.size() > 0) begin
                data_out = fifo_q.pop_front();
                exp_q.push_back(data_out);
            end
        end
        if (stall && ARESETn) begin
            chk("hold_tvalid", M_AXIS_TVALID, 1'b1);
            chk("hold_tdata", M_AXIS_TDATA, p_dat);
            chk("hold_tlast", M_AXIS_TLAST, p_last);
        end
    endtask

    task automatic run_until_beat(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && beat < target; i++) tick();
        chk(tag, beat, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 1'b0);
        chk({tag, "_tvalid"}, M_AXIS_TVALID, 1'b0);
        chk({tag, "_tlast"}, M_AXIS_TLAST, 1'b0);
        chk({tag, "_tdata"}, M_AXIS_TDATA, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_pkt_count"}, pkt_count, '0);
    endtask

    initial begin
        ARESETn = 1'b0; enable = 1'b0; M_AXIS_TREADY = 1'b0; hold_empty = 1'b0;
        data_out = '0; fifo_empty = 1'b1; next_word = 1;
        beat = 0; pkts = 0; n_fired = 0; cyc = 0;
        first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1;

        // Reset with enable low and a loaded FIFO: nothing moves.
        push_words(16);
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESETn = 1'b1;
        repeat (10) tick();
        chk("idle_fires", n_fired, 0);
        chk("idle_tvalid", M_AXIS_TVALID, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Two full packets at full rate.
        enable = 1'b1; M_AXIS_TREADY = 1'b1;
        run_until_beat(16, 60, "burst16_beats");
        chk("first_latency", first_v - first_rd, 2);
        chk("throughput_span", last_hs - first_hs, 15);
        chk("pkt_count_burst", pkt_count, exp_pkts());
        chk("busy_run", busy, 1'b1);

        // Sink stall mid-stream.
        push_words(24);
        run_until_beat(20, 40, "pre_stall_beats");
        M_AXIS_TREADY = 1'b0;
        repeat (10) tick();
        chk("stall_buffered", exp_q.size(), 2);
        chk("stall_rd_en", rd_en, 1'b0);
        chk("stall_tvalid", M_AXIS_TVALID, 1'b1);
        M_AXIS_TREADY = 1'b1;
        run_until_beat(40, 60, "post_stall_beats");
        chk("post_stall_drained", exp_q.size(), 0);

        // Source runs dry mid-packet.
        push_words(5);
        repeat (10) tick();
        chk("gap_beats_a", beat, 45);
        repeat (20) tick();
        chk("gap_beats_b", beat, 45);
        chk("gap_tvalid", M_AXIS_TVALID, 1'b0);
        push_words(3);
        run_until_beat(48, 20, "post_gap_beats");
        chk("pkt_count_gap", pkt_count, exp_pkts());

        // enable drops after 3 reads: the packet completes, the rest stays in the FIFO.
        push_words(10);
        base = n_fired;
        for (int i = 0; i < 20 && (n_fired - base) < 3; i++) tick();
        enable = 1'b0;
        run_until_beat(56, 40, "finish_beats");
        chk("finish_busy", busy, 1'b0);
        chk("finish_fifo_left", fifo_q.size(), 2);
        repeat (10) tick();
        chk("finish_reads", n_fired - base, 8);
        chk("finish_idle_busy", busy, 1'b0);
        chk("pkt_count_finish", pkt_count, exp_pkts());

        // Reset in the middle of a packet.
        push_words(20);
        enable = 1'b1;
        run_until_beat(60, 30, "pre_reset_beats");
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        beat = 0; pkts = 0;
        repeat (2) tick();
        ARESETn = 1'b1;
        run_until_beat(8, 40, "post_reset_beats");
        chk("pkt_count_post_reset", pkt_count, exp_pkts());

        // Randomized backpressure, source gaps and enable toggling.
        push_words(200);
        for (int i = 0; i < 1500 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) begin
            M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            hold_empty    = ($urandom_range(0, 4) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            tick();
        end
        M_AXIS_TREADY = 1'b1; hold_empty = 1'b0; enable = 1'b1;
        for (int i = 0; i < 100 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) tick();
        chk("rand_fifo_drained", fifo_q.size(), 0);
        chk("rand_stream_drained", exp_q.size(), 0);
        chk("pkt_count_rand", pkt_count, exp_pkts());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_axis_drain.md
Name: fifo_axis_drain

Overview:
- Downstream neighbour of the CSR-controlled sample FIFO.
- Drains FIFO words via rd_en/data_out and emits them as an AXI4-Stream master, framing the stream into fixed-length packets (TLAST every PKT_LEN beats).
- Packet-atomic: once a packet has started, it is always completed before the block idles.
- Sits between the FIFO and the downstream DMA/processing stream.

Parameters:
DATA_WIDTH, 32, FIFO word and TDATA width
PKT_LEN, 8, beats per packet; legal range 2..65535
CNT_WIDTH, 16, width of the beat counters and pkt_count

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
enable  in  1  drain enable, level-sensitive (driven from CSR CONTROL)
fifo_empty  in  1  FIFO empty flag
rd_en  out  1  FIFO read strobe
data_out  in  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after rd_en
M_AXIS_TDATA  out  DATA_WIDTH  stream data
M_AXIS_TVALID  out  1  stream valid
M_AXIS_TREADY  in  1  stream ready
M_AXIS_TLAST  out  1  last beat of packet
busy  out  1  high when state != IDLE or any data is buffered/in flight
pkt_count  out  CNT_WIDTH  completed packets (optional feature)

Behaviour:
- Clock and reset: one clock, ACLK. ARESETn is asynchronous, active-low.
- Reset values: rd_en=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, busy=0, pkt_count=0. All counters cleared, state=IDLE, 2-entry output buffer emptied, in-flight read discarded.
- Reset mid-packet: the partial packet is abandoned; no TLAST is emitted for it.
- Output buffer: 2-entry. Head drives TDATA/TVALID/TLAST. An entry pops when TVALID&&TREADY.
- Read issue:
  - rd_en=1 iff read_allowed && !fifo_empty && (occupancy + inflight) < 2.
  - inflight is a 1-bit register holding last cycle's rd_en.
  - data_out is captured into the buffer on the cycle inflight=1, together with that word's TLAST tag.
- Latency:
  - Buffer empty, fifo_empty=0, enable=1: rd_en at cycle N, TVALID at cycle N+2.
  - With TREADY held high, sustained throughput is 1 beat/cycle.
- Issue counter:
  - issue_cnt counts reads issued, 0..PKT_LEN-1, wrapping to 0.
  - The word read at issue_cnt==PKT_LEN-1 is tagged TLAST=1.
- State machine:
  - IDLE: read_allowed=0. Go to RUN when enable=1.
  - RUN: read_allowed=1.
    - enable falls with issue_cnt==0: go to IDLE.
    - enable falls with issue_cnt!=0: go to FINISH.
  - FINISH: read_allowed=1 only until the tagged-last read is issued (issue_cnt returns to 0), then IDLE. enable rising in FINISH returns to RUN.
- In IDLE the buffered beats still drain to the stream; enable only gates new reads.
- AXI-Stream rules:
  - Once TVALID=1, TDATA/TLAST hold stable until the handshake.
  - TVALID never depends combinationally on TREADY.
- Boundary conditions:
  - fifo_empty mid-packet: stall reads with no timeout and no padding; resume on the same beat index.
  - Simultaneous capture and pop: occupancy unchanged, order preserved.
  - TREADY=0 with buffer full: rd_en=0. No word is ever dropped or duplicated.
  - issue_cnt wraps exactly at PKT_LEN. Any TLAST mis-tag is a failure.

Optional Feature:
- Macro: FIFO_AXIS_DRAIN_STATS_EN.
- Defined: pkt_count increments on each TLAST handshake (TVALID&&TREADY&&TLAST) and wraps modulo 2^CNT_WIDTH. Cleared only by reset.
- Undefined: pkt_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset with enable=0, FIFO holding 1..16 -> rd_en stays 0, TVALID=0, busy=0.
- enable=1, FIFO holds 1..16, TREADY=1, PKT_LEN=8 -> beats 1..16 in order; TLAST on 8 and 16; first TVALID 2 cycles after first rd_en; pkt_count=2 when stats enabled.
- TREADY held 0 for 10 cycles mid-stream -> exactly 2 words buffered, rd_en=0, TDATA stable. On release, sequence continues with no gap or duplicate.
- FIFO supplies 1..5, then fifo_empty=1 for 20 cycles, then 6..8 -> stream stalls after beat 5; TLAST only on beat 8.
- enable dropped after 3 beats issued, FIFO holds 1..10 -> block finishes beats 4..8, TLAST on 8, returns to IDLE; words 9..10 remain in the FIFO; busy falls after the last handshake.
- ARESETn asserted mid-packet at beat 4 -> all outputs 0 immediately. After release with enable=1, the next beat is the first of a new packet and TLAST falls PKT_LEN beats later.
